// File: rtl/sdram_responder_pkg.sv
// Shared encodings for the SDRAM responder: command codes, mode-word fields,
// legal CL/BL codes, burst FSM states and geometry defaults.
package sdram_responder_pkg;

    localparam logic [2:0] CMD_LOAD_MODE = 3'b000;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_TERMINATE = 3'b110;
    localparam logic [2:0] CMD_NOP       = 3'b111;

    localparam int MODE_CL_LSB = 4;
    localparam int MODE_BL_LSB = 0;
    localparam int AP_BIT      = 10;

    localparam logic [2:0] CL_2 = 3'd2;
    localparam logic [2:0] CL_3 = 3'd3;

    localparam logic [2:0] BL_1    = 3'b000;
    localparam logic [2:0] BL_2    = 3'b001;
    localparam logic [2:0] BL_4    = 3'b010;
    localparam logic [2:0] BL_8    = 3'b011;
    localparam logic [2:0] BL_PAGE = 3'b111;

    localparam int DEF_COL_W = 9;
    localparam int DEF_ROW_W = 13;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    function automatic logic cl_legal(input logic [2:0] c);
        return (c == CL_2) || (c == CL_3);
    endfunction

    function automatic logic bl_legal(input logic [2:0] c);
        return (c == BL_1) || (c == BL_2) || (c == BL_4) || (c == BL_8) || (c == BL_PAGE);
    endfunction

    // Burst length minus one; doubles as the column wrap mask for BL 2/4/8.
    function automatic logic [3:0] bl_last(input logic [2:0] c);
        case (c)
            BL_2:    return 4'd1;
            BL_4:    return 4'd3;
            BL_8:    return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Single-port synchronous backing RAM, 16-bit words, per-byte write enable,
// one-cycle registered read. Contents are never reset.
module sdram_resp_mem #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    we,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we[0]) mem[addr][7:0]  <= wdata[7:0];
            if (we[1]) mem[addr][15:8] <= wdata[15:8];
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sdram_responder.sv
// Device-side SDRAM model: decodes the controller command bus, tracks banks,
// mode register and bursts, and answers reads with CL 2/3 timing.
module sdram_responder
    import sdram_responder_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int COL_W  = DEF_COL_W,
    parameter int ROW_W  = DEF_ROW_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_cke,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_addr,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        mode_loaded,
    output logic        cmd_err,
    output logic [15:0] refresh_cnt
);

    logic [2:0]        cmd;
    logic [3:0]        bank_open;
    logic [ROW_W-1:0]  open_row [4];
    logic              mode_cl3;
    logic [2:0]        mode_bl;
    state_t            state, state_nx;
    logic [1:0]        bst_bank, mem_bank;
    logic [COL_W-1:0]  bst_col, bst_col_nx, mem_col, wrap_mask;
    logic [3:0]        bst_left, bst_left_nx;
    logic [2:0]        lmr_cl, lmr_bl;
    logic              page_mode, ok_act, ok_rw, ok_ref, ok_lmr, err, pre_hit, cancel;
    logic              issue_rd, wr_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [1:0]        mem_we;
    logic [15:0]       mem_rdata, hold_d;
    logic [1:0]        vld_pipe;

    function automatic logic [COL_W-1:0] col_adv(input logic [COL_W-1:0] c,
                                                 input logic [COL_W-1:0] m);
        return (c & ~m) | ((c + 1'b1) & m);
    endfunction

    assign cmd = (sdram_cke && !sdram_cs_n) ? {sdram_ras_n, sdram_cas_n, sdram_we_n} : CMD_NOP;
    assign lmr_cl = sdram_addr[MODE_CL_LSB +: 3];
    assign lmr_bl = sdram_addr[MODE_BL_LSB +: 3];

    assign ok_act = (cmd == CMD_ACTIVE) && mode_loaded && !bank_open[sdram_ba];
    assign ok_rw  = (cmd == CMD_READ || cmd == CMD_WRITE) && mode_loaded && bank_open[sdram_ba];
    assign ok_ref = (cmd == CMD_REFRESH) && (bank_open == 4'b0);
    assign ok_lmr = (cmd == CMD_LOAD_MODE) && (bank_open == 4'b0) && cl_legal(lmr_cl) && bl_legal(lmr_bl);
    assign err    = ((cmd == CMD_ACTIVE) && !ok_act)
                 || ((cmd == CMD_READ || cmd == CMD_WRITE) && !ok_rw)
                 || ((cmd == CMD_REFRESH) && !ok_ref)
                 || ((cmd == CMD_LOAD_MODE) && !ok_lmr);
    assign pre_hit = (cmd == CMD_PRECHARGE) && (sdram_addr[AP_BIT] || sdram_ba == bst_bank);
    assign cancel  = ok_rw && (cmd == CMD_WRITE);

    assign page_mode = (mode_bl == BL_PAGE);
    assign wrap_mask = page_mode ? '1 : COL_W'(bl_last(mode_bl));

    always_comb begin
        state_nx    = state;
        bst_col_nx  = bst_col;
        bst_left_nx = bst_left;
        issue_rd    = 1'b0;
        wr_en       = 1'b0;
        mem_bank    = bst_bank;
        mem_col     = bst_col;
        if (ok_rw) begin
            // A legal READ/WRITE always (re)starts a burst, even mid-burst.
            mem_bank    = sdram_ba;
            mem_col     = sdram_addr[COL_W-1:0];
            issue_rd    = (cmd == CMD_READ);
            wr_en       = (cmd == CMD_WRITE);
            bst_col_nx  = col_adv(sdram_addr[COL_W-1:0], wrap_mask);
            bst_left_nx = bl_last(mode_bl);
            if (page_mode || bl_last(mode_bl) != 4'd0)
                state_nx = (cmd == CMD_READ) ? RD_BURST : WR_BURST;
            else
                state_nx = IDLE;
        end else if (state != IDLE) begin
            if (cmd == CMD_TERMINATE || pre_hit) begin
                state_nx = IDLE;
            end else begin
                issue_rd    = (state == RD_BURST);
                wr_en       = (state == WR_BURST);
                bst_col_nx  = col_adv(bst_col, wrap_mask);
                bst_left_nx = bst_left - 4'd1;
                if (!page_mode && bst_left == 4'd1) state_nx = IDLE;
            end
        end
    end

    assign mem_addr = MEM_AW'({mem_bank, open_row[mem_bank], mem_col});
    assign mem_we   = (wr_en && rst_n) ? ~sdram_dqm : 2'b00;

    sdram_resp_mem #(.AW(MEM_AW)) u_mem (
        .clk   (clk),
        .en    (sdram_cke),
        .addr  (mem_addr),
        .we    (mem_we),
        .wdata (dq_in),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bst_bank    <= 2'd0;
            bst_col     <= '0;
            bst_left    <= 4'd0;
            bank_open   <= 4'b0;
            for (int i = 0; i < 4; i++) open_row[i] <= '0;
            mode_cl3    <= 1'b1;
            mode_bl     <= BL_1;
            mode_loaded <= 1'b0;
            cmd_err     <= 1'b0;
            refresh_cnt <= 16'd0;
            vld_pipe    <= 2'b0;
            hold_d      <= 16'd0;
            dq_out      <= 16'd0;
            dq_oe       <= 1'b0;
        end else if (sdram_cke) begin
            state    <= state_nx;
            bst_col  <= bst_col_nx;
            bst_left <= bst_left_nx;
            cmd_err  <= err;
            if (ok_rw) bst_bank <= sdram_ba;
            if (ok_act) begin
                bank_open[sdram_ba] <= 1'b1;
                open_row[sdram_ba]  <= sdram_addr[ROW_W-1:0];
            end
            if (cmd == CMD_PRECHARGE) begin
                if (sdram_addr[AP_BIT]) bank_open <= 4'b0;
                else                    bank_open[sdram_ba] <= 1'b0;
            end
            if (ok_ref && refresh_cnt != 16'hFFFF) refresh_cnt <= refresh_cnt + 16'd1;
            if (ok_lmr) begin
                mode_loaded <= 1'b1;
                mode_cl3    <= (lmr_cl == CL_3);
                mode_bl     <= lmr_bl;
            end
            // Stage 0 is the RAM read; CL3 adds one hold stage before dq_out.
            if (cancel) begin
                vld_pipe <= 2'b0;
                dq_oe    <= 1'b0;
            end else begin
                vld_pipe <= {vld_pipe[0], issue_rd};
                hold_d   <= mem_rdata;
                dq_oe    <= mode_cl3 ? vld_pipe[1] : vld_pipe[0];
                dq_out   <= mode_cl3 ? hold_d : mem_rdata;
            end
        end
    end

endmodule
